// File: rtl/riscv_load_wb_queue.sv
// riscv_load_wb_queue
// In-order load write-back queue feeding register-file write port B.
// Each issued load records {rd, size, sext, off}. Responses return in order,
// are aligned and extended using the head entry, and are written back one
// cycle after the response. hazard_o flags reads of registers with a load
// still in flight, or with a write-back that has not committed yet.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   issue_*_i / _o      load issue handshake and format fields
//   rsp_valid_i/rdata_i memory response (in order)
//   raddr_{a,b,c}_i     register-file read addresses checked for hazards
//   hazard_o            combinational RAW hazard flag
//   we_b_o/waddr_b_o/wdata_b_o  register-file port B write
//   rsp_err_o           sticky: response arrived while queue was empty
//   pending_o           number of outstanding loads
//
// Optional build macro RISCV_LOAD_WBQ_PERF_EN adds hazard_cycles_o, a
// saturating count of cycles with hazard_o asserted.

module riscv_load_wb_queue #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         issue_valid_i,
  output logic                         issue_ready_o,
  input  logic [ADDR_WIDTH-1:0]        issue_rd_i,
  input  logic [1:0]                   issue_size_i,
  input  logic                         issue_sext_i,
  input  logic [1:0]                   issue_off_i,
  input  logic                         rsp_valid_i,
  input  logic [DATA_WIDTH-1:0]        rsp_rdata_i,
  input  logic [ADDR_WIDTH-1:0]        raddr_a_i,
  input  logic [ADDR_WIDTH-1:0]        raddr_b_i,
  input  logic [ADDR_WIDTH-1:0]        raddr_c_i,
  output logic                         hazard_o,
  output logic                         we_b_o,
  output logic [ADDR_WIDTH-1:0]        waddr_b_o,
  output logic [DATA_WIDTH-1:0]        wdata_b_o,
  output logic                         rsp_err_o,
  output logic [$clog2(DEPTH):0]       pending_o
`ifdef RISCV_LOAD_WBQ_PERF_EN
  ,
  output logic [31:0]                  hazard_cycles_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Entry storage (data only, no reset needed)
  logic [ADDR_WIDTH-1:0] rd_mem   [DEPTH];
  logic [1:0]            size_mem [DEPTH];
  logic                  sext_mem [DEPTH];
  logic [1:0]            off_mem  [DEPTH];

  logic [PTR_W-1:0]      wptr_q, wptr_d;
  logic [PTR_W-1:0]      rptr_q, rptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  err_q, err_d;

  logic push, pop;

  // Align the raw word by the byte offset, then pick and extend the field.
  function automatic logic [DATA_WIDTH-1:0] fmt_load(
    input logic [DATA_WIDTH-1:0] raw,
    input logic [1:0]            size,
    input logic                  sext,
    input logic [1:0]            off
  );
    logic [DATA_WIDTH-1:0] sh;
    sh = raw >> {off, 3'b000};
    case (size)
      2'b00:   fmt_load = {{(DATA_WIDTH-8){sext & sh[7]}}, sh[7:0]};
      2'b01:   fmt_load = {{(DATA_WIDTH-16){sext & sh[15]}}, sh[15:0]};
      default: fmt_load = sh;  // word; size 11 behaves as word
    endcase
  endfunction

  // x0 never creates a hazard, so a zero read address never matches.
  function automatic logic addr_hit(
    input logic [ADDR_WIDTH-1:0] rd,
    input logic [ADDR_WIDTH-1:0] raddr
  );
    addr_hit = (raddr != '0) && (rd == raddr);
  endfunction

  assign issue_ready_o = (count_q < CNT_W'(DEPTH));
  assign push          = issue_valid_i && issue_ready_o;
  assign pop           = rsp_valid_i && (count_q != '0);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop) begin
      rptr_d  = rptr_q + 1'b1;
      we_d    = 1'b1;
      waddr_d = rd_mem[rptr_q];
      wdata_d = fmt_load(rsp_rdata_i, size_mem[rptr_q], sext_mem[rptr_q], off_mem[rptr_q]);
    end
    if (rsp_valid_i && (count_q == '0)) err_d = 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wptr_q]   <= issue_rd_i;
      size_mem[wptr_q] <= issue_size_i;
      sext_mem[wptr_q] <= issue_sext_i;
      off_mem[wptr_q]  <= issue_off_i;
    end
  end

  // Hazard: any entry from rptr upward for count slots is in flight; the
  // registered write-back is also checked since it commits at the next edge.
  always_comb begin
    logic [PTR_W-1:0] idx;
    hazard_o = 1'b0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rptr_q + PTR_W'(i);
      if (CNT_W'(i) < count_q) begin
        if (addr_hit(rd_mem[idx], raddr_a_i) ||
            addr_hit(rd_mem[idx], raddr_b_i) ||
            addr_hit(rd_mem[idx], raddr_c_i))
          hazard_o = 1'b1;
      end
    end
    if (we_q && (addr_hit(waddr_q, raddr_a_i) ||
                 addr_hit(waddr_q, raddr_b_i) ||
                 addr_hit(waddr_q, raddr_c_i)))
      hazard_o = 1'b1;
  end

  assign we_b_o    = we_q;
  assign waddr_b_o = waddr_q;
  assign wdata_b_o = wdata_q;
  assign rsp_err_o = err_q;
  assign pending_o = count_q;

`ifdef RISCV_LOAD_WBQ_PERF_EN
  logic [31:0] hcyc_q, hcyc_d;

  always_comb begin
    hcyc_d = hcyc_q;
    if (hazard_o && (hcyc_q != 32'hFFFF_FFFF)) hcyc_d = hcyc_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) hcyc_q <= '0;
    else     hcyc_q <= hcyc_d;
  end

  assign hazard_cycles_o = hcyc_q;
`endif

endmodule

// File: tb/tb_riscv_load_wb_queue.sv
// Directed testbench for riscv_load_wb_queue (default parameters).
module tb_riscv_load_wb_queue;

  logic        clk;
  logic        rst;
  logic        issue_valid_i;
  logic        issue_ready_o;
  logic [5:0]  issue_rd_i;
  logic [1:0]  issue_size_i;
  logic        issue_sext_i;
  logic [1:0]  issue_off_i;
  logic        rsp_valid_i;
  logic [31:0] rsp_rdata_i;
  logic [5:0]  raddr_a_i;
  logic [5:0]  raddr_b_i;
  logic [5:0]  raddr_c_i;
  logic        hazard_o;
  logic        we_b_o;
  logic [5:0]  waddr_b_o;
  logic [31:0] wdata_b_o;
  logic        rsp_err_o;
  logic [2:0]  pending_o;
`ifdef RISCV_LOAD_WBQ_PERF_EN
  logic [31:0] hazard_cycles_o;
`endif

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  riscv_load_wb_queue #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .issue_valid_i (issue_valid_i),
    .issue_ready_o (issue_ready_o),
    .issue_rd_i    (issue_rd_i),
    .issue_size_i  (issue_size_i),
    .issue_sext_i  (issue_sext_i),
    .issue_off_i   (issue_off_i),
    .rsp_valid_i   (rsp_valid_i),
    .rsp_rdata_i   (rsp_rdata_i),
    .raddr_a_i     (raddr_a_i),
    .raddr_b_i     (raddr_b_i),
    .raddr_c_i     (raddr_c_i),
    .hazard_o      (hazard_o),
    .we_b_o        (we_b_o),
    .waddr_b_o     (waddr_b_o),
    .wdata_b_o     (wdata_b_o),
    .rsp_err_o     (rsp_err_o),
    .pending_o     (pending_o)
`ifdef RISCV_LOAD_WBQ_PERF_EN
    ,
    .hazard_cycles_o (hazard_cycles_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [5:0] rd, input logic [1:0] size,
                       input logic sext, input logic [1:0] off);
    issue_valid_i = 1'b1;
    issue_rd_i    = rd;
    issue_size_i  = size;
    issue_sext_i  = sext;
    issue_off_i   = off;
    step();
    issue_valid_i = 1'b0;
  endtask

  task automatic respond(input logic [31:0] data);
    rsp_valid_i = 1'b1;
    rsp_rdata_i = data;
    step();
    rsp_valid_i = 1'b0;
  endtask

  task automatic load_fmt(input string tag, input logic [5:0] rd, input logic [1:0] size,
                          input logic sext, input logic [1:0] off,
                          input logic [31:0] raw, input logic [31:0] exp);
    issue(rd, size, sext, off);
    respond(raw);
    chk({tag, "_we"}, {31'd0, we_b_o}, 32'd1);
    chk({tag, "_data"}, wdata_b_o, exp);
    step();
  endtask

  initial begin
    rst = 1'b1;
    issue_valid_i = 1'b0; issue_rd_i = '0; issue_size_i = '0;
    issue_sext_i = 1'b0; issue_off_i = '0;
    rsp_valid_i = 1'b0; rsp_rdata_i = '0;
    raddr_a_i = '0; raddr_b_i = '0; raddr_c_i = '0;
    step(); step();
    rst = 1'b0;

    // Reset state
    chk("rst_pending", {29'd0, pending_o}, 32'd0);
    chk("rst_ready",   {31'd0, issue_ready_o}, 32'd1);
    chk("rst_we",      {31'd0, we_b_o}, 32'd0);
    chk("rst_waddr",   {26'd0, waddr_b_o}, 32'd0);
    chk("rst_wdata",   wdata_b_o, 32'd0);
    chk("rst_err",     {31'd0, rsp_err_o}, 32'd0);
    chk("rst_hazard",  {31'd0, hazard_o}, 32'd0);

    // Basic word load
    issue(6'd5, 2'b10, 1'b0, 2'd0);
    chk("w_pend1", {29'd0, pending_o}, 32'd1);
    respond(32'hDEADBEEF);
    chk("w_we",    {31'd0, we_b_o}, 32'd1);
    chk("w_waddr", {26'd0, waddr_b_o}, 32'd5);
    chk("w_wdata", wdata_b_o, 32'hDEADBEEF);
    chk("w_pend0", {29'd0, pending_o}, 32'd0);
    step();
    chk("w_we_low", {31'd0, we_b_o}, 32'd0);
    chk("w_hold",   wdata_b_o, 32'hDEADBEEF);

    // Formatting
    load_fmt("bs_off2", 6'd7, 2'b00, 1'b1, 2'd2, 32'h0080_0000, 32'hFFFF_FF80);
    load_fmt("bz_off2", 6'd7, 2'b00, 1'b0, 2'd2, 32'h0080_0000, 32'h0000_0080);
    load_fmt("hs_off2", 6'd7, 2'b01, 1'b1, 2'd2, 32'h8001_0000, 32'hFFFF_8001);
    load_fmt("hz_off0", 6'd7, 2'b01, 1'b0, 2'd0, 32'h1234_F00D, 32'h0000_F00D);
    load_fmt("bs_off3", 6'd7, 2'b00, 1'b1, 2'd3, 32'h7F00_0000, 32'h0000_007F);
    load_fmt("sz11",    6'd7, 2'b11, 1'b1, 2'd0, 32'h8765_4321, 32'h8765_4321);

    // Fill, drop when full, drain in order
    issue(6'd1, 2'b10, 1'b0, 2'd0);
    issue(6'd2, 2'b10, 1'b0, 2'd0);
    issue(6'd3, 2'b10, 1'b0, 2'd0);
    chk("fill_ready3", {31'd0, issue_ready_o}, 32'd1);
    issue(6'd4, 2'b10, 1'b0, 2'd0);
    chk("full_ready", {31'd0, issue_ready_o}, 32'd0);
    chk("full_pend",  {29'd0, pending_o}, 32'd4);
    issue(6'd20, 2'b10, 1'b0, 2'd0);
    chk("drop_pend",  {29'd0, pending_o}, 32'd4);
    rsp_valid_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      rsp_rdata_i = 32'h100 + k;
      step();
      chk($sformatf("drain_waddr%0d", k), {26'd0, waddr_b_o}, k);
      chk($sformatf("drain_wdata%0d", k), wdata_b_o, 32'h100 + k);
    end
    rsp_valid_i = 1'b0;
    chk("drain_pend0", {29'd0, pending_o}, 32'd0);
    step();
    chk("drain_err", {31'd0, rsp_err_o}, 32'd0);

    // Full queue: a response does not open room in the same cycle
    issue(6'd10, 2'b10, 1'b0, 2'd0);
    issue(6'd11, 2'b10, 1'b0, 2'd0);
    issue(6'd12, 2'b10, 1'b0, 2'd0);
    issue(6'd13, 2'b10, 1'b0, 2'd0);
    issue_valid_i = 1'b1; issue_rd_i = 6'd30;
    rsp_valid_i = 1'b1;   rsp_rdata_i = 32'hA;
    step();
    chk("fullpop_pend",  {29'd0, pending_o}, 32'd3);
    chk("fullpop_waddr", {26'd0, waddr_b_o}, 32'd10);
    // Simultaneous push and pop with room
    issue_rd_i = 6'd14; rsp_rdata_i = 32'hB;
    step();
    chk("pp_pend",  {29'd0, pending_o}, 32'd3);
    chk("pp_waddr", {26'd0, waddr_b_o}, 32'd11);
    rsp_valid_i = 1'b0;
    issue_rd_i = 6'd15;
    step();
    issue_valid_i = 1'b0;
    chk("wrap_pend",  {29'd0, pending_o}, 32'd4);
    chk("wrap_ready", {31'd0, issue_ready_o}, 32'd0);
    rsp_valid_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rsp_rdata_i = k;
      step();
      chk($sformatf("wrap_waddr%0d", k), {26'd0, waddr_b_o}, 12 + k);
    end
    rsp_valid_i = 1'b0;
    chk("wrap_pend0", {29'd0, pending_o}, 32'd0);
    step();

    // Hazards
    issue(6'd9, 2'b10, 1'b0, 2'd0);
    raddr_b_i = 6'd9; #1;
    chk("haz_b9", {31'd0, hazard_o}, 32'd1);
    raddr_b_i = 6'd8; #1;
    chk("haz_b8", {31'd0, hazard_o}, 32'd0);
    raddr_c_i = 6'd41; #1;
    chk("haz_fp41", {31'd0, hazard_o}, 32'd0);
    raddr_c_i = 6'd9; #1;
    chk("haz_c9", {31'd0, hazard_o}, 32'd1);
    raddr_c_i = 6'd0; raddr_b_i = 6'd9;
    respond(32'h99);
    chk("haz_wb_we", {31'd0, we_b_o}, 32'd1);
    chk("haz_wb",    {31'd0, hazard_o}, 32'd1);
    step();
    chk("haz_clear", {31'd0, hazard_o}, 32'd0);
    raddr_b_i = 6'd0;
    issue(6'd0, 2'b10, 1'b0, 2'd0);
    chk("haz_x0_pend", {29'd0, pending_o}, 32'd1);
    chk("haz_x0",      {31'd0, hazard_o}, 32'd0);
    respond(32'h55);
    chk("x0_we",    {31'd0, we_b_o}, 32'd1);
    chk("x0_waddr", {26'd0, waddr_b_o}, 32'd0);
    chk("x0_haz",   {31'd0, hazard_o}, 32'd0);
    step();

    // Response with empty queue
    respond(32'hBAD);
    chk("err_set", {31'd0, rsp_err_o}, 32'd1);
    chk("err_we",  {31'd0, we_b_o}, 32'd0);
    step();
    chk("err_sticky", {31'd0, rsp_err_o}, 32'd1);

    // Reset mid-queue, then a late response
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst2_err", {31'd0, rsp_err_o}, 32'd0);
    issue(6'd3, 2'b10, 1'b0, 2'd0);
    issue(6'd4, 2'b10, 1'b0, 2'd0);
    chk("mid_pend2", {29'd0, pending_o}, 32'd2);
    rst = 1'b1; step(); rst = 1'b0;
    chk("mid_pend0",  {29'd0, pending_o}, 32'd0);
    chk("mid_ready",  {31'd0, issue_ready_o}, 32'd1);
    respond(32'h1);
    chk("late_err", {31'd0, rsp_err_o}, 32'd1);
    chk("late_we",  {31'd0, we_b_o}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
